// File: rtl/decode_stage.sv
// Registered, handshaked decode stage for the Jac1-8 core: decodes one fetch word per cycle,
// stalls on register/status read-after-write hazards, resolves branches and discards wrong-path fetches.
module decode_stage #(
  parameter int PROGRAM_DataWidth = 16,
  parameter int NumOpCodeBits     = 5,
  parameter int SEL_WIDTH         = 2,
  parameter int OP1_BIT_POS       = 9,
  parameter int OP2_BIT_POS       = 4,
  parameter int ParamBits         = 8,
  parameter int NumStatusBits     = 6,
  parameter int FLUSH_CYCLES      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [PROGRAM_DataWidth-1:0] i_instruction,
  input  logic [NumStatusBits-1:0]     i_status,
  input  logic                         i_wb_valid,
  input  logic [SEL_WIDTH-1:0]         i_wb_sel,
  input  logic                         i_stat_wb,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [NumOpCodeBits-1:0]     o_opcode,
  output logic [ParamBits-1:0]         o_param,
  output logic [ParamBits-1:0]         o_literal_adr,
  output logic                         o_rd_en1,
  output logic                         o_rd_en2,
  output logic                         o_wr_en,
  output logic                         o_stat_wr_en,
  output logic                         o_sel_reg_in_alu_decoder,
  output logic                         o_cnt_wr_en,
  output logic                         o_add_offset,
  output logic [SEL_WIDTH-1:0]         o_rd_sel1,
  output logic [SEL_WIDTH-1:0]         o_rd_sel2,
  output logic [SEL_WIDTH-1:0]         o_wr_sel,
  output logic                         o_illegal
);

  localparam int NUM_REGS = 2 ** SEL_WIDTH;
  localparam int CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam int Z_BIT    = 2;
  localparam int EQ_BIT   = 3;
  localparam int ST_BIT   = 4;
  localparam int GT_BIT   = 5;

  localparam logic [NumOpCodeBits-1:0] OP_NOP  = NumOpCodeBits'(5'h00);
  localparam logic [NumOpCodeBits-1:0] OP_ADD  = NumOpCodeBits'(5'h01);
  localparam logic [NumOpCodeBits-1:0] OP_SUB  = NumOpCodeBits'(5'h02);
  localparam logic [NumOpCodeBits-1:0] OP_AND  = NumOpCodeBits'(5'h03);
  localparam logic [NumOpCodeBits-1:0] OP_OR   = NumOpCodeBits'(5'h04);
  localparam logic [NumOpCodeBits-1:0] OP_XOR  = NumOpCodeBits'(5'h05);
  localparam logic [NumOpCodeBits-1:0] OP_NOT  = NumOpCodeBits'(5'h06);
  localparam logic [NumOpCodeBits-1:0] OP_SHL  = NumOpCodeBits'(5'h07);
  localparam logic [NumOpCodeBits-1:0] OP_SHR  = NumOpCodeBits'(5'h08);
  localparam logic [NumOpCodeBits-1:0] OP_VAL  = NumOpCodeBits'(5'h09);
  localparam logic [NumOpCodeBits-1:0] OP_GOTO = NumOpCodeBits'(5'h10);
  localparam logic [NumOpCodeBits-1:0] OP_IFZ  = NumOpCodeBits'(5'h11);
  localparam logic [NumOpCodeBits-1:0] OP_IFNZ = NumOpCodeBits'(5'h12);
  localparam logic [NumOpCodeBits-1:0] OP_IFEQ = NumOpCodeBits'(5'h13);
  localparam logic [NumOpCodeBits-1:0] OP_IFST = NumOpCodeBits'(5'h14);
  localparam logic [NumOpCodeBits-1:0] OP_IFGT = NumOpCodeBits'(5'h15);

  typedef enum logic [1:0] {S_RUN, S_HAZARD, S_FLUSH} state_t;

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [NUM_REGS-1:0]        r_sb;
  logic                       r_stat_pend;

  logic [NumOpCodeBits-1:0]   w_op;
  logic [SEL_WIDTH-1:0]       w_op1;
  logic [SEL_WIDTH-1:0]       w_op2;
  logic [ParamBits-1:0]       w_param;
  logic                       w_rd_en1, w_rd_en2, w_wr_en, w_stat_wr_en, w_sel;
  logic                       w_cnt_wr_en, w_add_offset, w_illegal, w_is_cond;
  logic [SEL_WIDTH-1:0]       w_rd_sel1, w_rd_sel2, w_wr_sel;
  logic                       w_hazard, w_in_ready, w_in_fire, w_out_fire, w_load;
  logic [NUM_REGS-1:0]        w_sb_set, w_sb_clr;
  logic                       w_unused;

  assign w_op     = i_instruction[PROGRAM_DataWidth-1 -: NumOpCodeBits];
  assign w_op1    = i_instruction[OP1_BIT_POS -: SEL_WIDTH];
  assign w_op2    = i_instruction[OP2_BIT_POS -: SEL_WIDTH];
  assign w_param  = i_instruction[ParamBits-1:0];
  assign w_unused = ^{i_instruction, i_status};

  always_comb begin
    w_rd_en1     = 1'b0;
    w_rd_en2     = 1'b0;
    w_wr_en      = 1'b0;
    w_stat_wr_en = 1'b0;
    w_sel        = 1'b0;
    w_cnt_wr_en  = 1'b0;
    w_add_offset = 1'b0;
    w_illegal    = 1'b0;
    w_is_cond    = 1'b0;
    w_rd_sel1    = '0;
    w_rd_sel2    = '0;
    w_wr_sel     = '0;
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        w_rd_en1 = 1'b1; w_rd_sel1 = w_op1;
        w_rd_en2 = 1'b1; w_rd_sel2 = w_op2;
        w_wr_en = 1'b1; w_wr_sel = w_op1; w_stat_wr_en = 1'b1; w_sel = 1'b1;
      end
      OP_NOT: begin
        w_rd_en2 = 1'b1; w_rd_sel2 = w_op2;
        w_wr_en = 1'b1; w_wr_sel = w_op1; w_stat_wr_en = 1'b1; w_sel = 1'b1;
      end
      OP_SHL, OP_SHR: begin
        w_rd_en1 = 1'b1; w_rd_sel1 = w_op1;
        w_wr_en = 1'b1; w_wr_sel = w_op1; w_stat_wr_en = 1'b1; w_sel = 1'b1;
      end
      OP_VAL: begin
        w_wr_en = 1'b1; w_wr_sel = w_op1;
      end
      OP_GOTO: w_cnt_wr_en = 1'b1;
      OP_IFZ: begin
        w_is_cond = 1'b1; w_cnt_wr_en = i_status[Z_BIT]; w_add_offset = i_status[Z_BIT];
      end
      OP_IFNZ: begin
        w_is_cond = 1'b1; w_cnt_wr_en = !i_status[Z_BIT]; w_add_offset = !i_status[Z_BIT];
      end
      OP_IFEQ: begin
        w_is_cond = 1'b1; w_cnt_wr_en = i_status[EQ_BIT]; w_add_offset = i_status[EQ_BIT];
      end
      OP_IFST: begin
        w_is_cond = 1'b1; w_cnt_wr_en = i_status[ST_BIT]; w_add_offset = i_status[ST_BIT];
      end
      OP_IFGT: begin
        w_is_cond = 1'b1; w_cnt_wr_en = i_status[GT_BIT]; w_add_offset = i_status[GT_BIT];
      end
      OP_NOP: ;
      default: w_illegal = 1'b1;
    endcase
  end

  // A valid output bundle has not reached the scoreboard yet, so its writes count as pending too.
  assign w_hazard =
      (w_rd_en1 & (r_sb[w_op1] | (o_out_valid & o_wr_en & (o_wr_sel == w_op1)))) |
      (w_rd_en2 & (r_sb[w_op2] | (o_out_valid & o_wr_en & (o_wr_sel == w_op2)))) |
      (w_is_cond & (r_stat_pend | (o_out_valid & o_stat_wr_en)));

  assign w_in_ready = (r_state == S_FLUSH) ||
                      ((r_state == S_RUN) && !w_hazard && (!o_out_valid || i_out_ready));
  assign o_in_ready = w_in_ready;
  assign w_in_fire  = i_in_valid & w_in_ready;
  assign w_out_fire = o_out_valid & i_out_ready;
  assign w_load     = w_in_fire & (r_state == S_RUN);

  assign w_sb_set = (w_out_fire && o_wr_en) ? (NUM_REGS'(1) << o_wr_sel) : '0;
  assign w_sb_clr = i_wb_valid ? (NUM_REGS'(1) << i_wb_sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_RUN, S_HAZARD: begin
          if (w_out_fire && o_cnt_wr_en) begin
            r_state <= S_FLUSH;
            r_cnt   <= CNT_W'(FLUSH_CYCLES);
          end else if (r_state == S_RUN && i_in_valid && w_hazard) begin
            r_state <= S_HAZARD;
          end else if (r_state == S_HAZARD && !w_hazard) begin
            r_state <= S_RUN;
          end
        end
        S_FLUSH: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb                     <= '0;
      r_stat_pend              <= 1'b0;
      o_out_valid              <= 1'b0;
      o_opcode                 <= '0;
      o_param                  <= '0;
      o_literal_adr            <= '0;
      o_rd_en1                 <= 1'b0;
      o_rd_en2                 <= 1'b0;
      o_wr_en                  <= 1'b0;
      o_stat_wr_en             <= 1'b0;
      o_sel_reg_in_alu_decoder <= 1'b0;
      o_cnt_wr_en              <= 1'b0;
      o_add_offset             <= 1'b0;
      o_rd_sel1                <= '0;
      o_rd_sel2                <= '0;
      o_wr_sel                 <= '0;
      o_illegal                <= 1'b0;
    end else begin
      r_sb        <= (r_sb & ~w_sb_clr) | w_sb_set;
      r_stat_pend <= (r_stat_pend & ~i_stat_wb) | (w_out_fire & o_stat_wr_en);
      o_illegal   <= 1'b0;
      if (w_load) begin
        o_out_valid              <= 1'b1;
        o_opcode                 <= w_op;
        o_param                  <= w_param;
        o_literal_adr            <= w_param;
        o_rd_en1                 <= w_rd_en1;
        o_rd_en2                 <= w_rd_en2;
        o_wr_en                  <= w_wr_en;
        o_stat_wr_en             <= w_stat_wr_en;
        o_sel_reg_in_alu_decoder <= w_sel;
        o_cnt_wr_en              <= w_cnt_wr_en;
        o_add_offset             <= w_add_offset;
        o_rd_sel1                <= w_rd_sel1;
        o_rd_sel2                <= w_rd_sel2;
        o_wr_sel                 <= w_wr_sel;
        o_illegal                <= w_illegal;
      end else if (w_out_fire) begin
        o_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of single-instruction decode vectors plus hand-written
// hazard, flush, hold and reset sequences, all checked through an expected-bundle queue.
module tb_decode_stage;

  localparam int WAIT_LIMIT = 40;

  localparam logic [4:0] OP_NOP  = 5'h00, OP_ADD = 5'h01, OP_SUB = 5'h02, OP_AND = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04, OP_XOR = 5'h05, OP_NOT = 5'h06, OP_SHL = 5'h07;
  localparam logic [4:0] OP_SHR  = 5'h08, OP_VAL = 5'h09, OP_GOTO = 5'h10, OP_IFZ = 5'h11;
  localparam logic [4:0] OP_IFNZ = 5'h12, OP_IFEQ = 5'h13, OP_IFST = 5'h14, OP_IFGT = 5'h15;

  logic        clk, rst_n;
  logic        i_in_valid, o_in_ready;
  logic [15:0] i_instruction;
  logic [5:0]  i_status;
  logic        i_wb_valid, i_stat_wb;
  logic [1:0]  i_wb_sel;
  logic        o_out_valid, i_out_ready;
  logic [4:0]  o_opcode;
  logic [7:0]  o_param, o_literal_adr;
  logic        o_rd_en1, o_rd_en2, o_wr_en, o_stat_wr_en, o_sel_reg_in_alu_decoder;
  logic        o_cnt_wr_en, o_add_offset, o_illegal;
  logic [1:0]  o_rd_sel1, o_rd_sel2, o_wr_sel;

  typedef struct packed {
    logic [4:0] opcode;
    logic [7:0] param;
    logic [7:0] lit;
    logic       rd1, rd2, wr, st, sel, cnt, add;
    logic [1:0] rs1, rs2, ws;
    logic       ill;
  } bundle_t;

  typedef struct {
    logic [4:0] op;
    logic [1:0] op1;
    logic [7:0] p;
    logic [5:0] st;
    logic [6:0] flags;
    logic [1:0] rs1, rs2, ws;
    logic       ill;
  } vec_t;

  bundle_t expQ[$];
  int      checks = 0;
  int      errors = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_instruction(i_instruction), .i_status(i_status), .i_wb_valid(i_wb_valid),
    .i_wb_sel(i_wb_sel), .i_stat_wb(i_stat_wb), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_opcode(o_opcode), .o_param(o_param),
    .o_literal_adr(o_literal_adr), .o_rd_en1(o_rd_en1), .o_rd_en2(o_rd_en2),
    .o_wr_en(o_wr_en), .o_stat_wr_en(o_stat_wr_en),
    .o_sel_reg_in_alu_decoder(o_sel_reg_in_alu_decoder), .o_cnt_wr_en(o_cnt_wr_en),
    .o_add_offset(o_add_offset), .o_rd_sel1(o_rd_sel1), .o_rd_sel2(o_rd_sel2),
    .o_wr_sel(o_wr_sel), .o_illegal(o_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [1:0] op1, input logic [7:0] p);
    return {op, 1'b0, op1, p};
  endfunction

  // Reference decode used by the hand-written sequences.
  function automatic bundle_t expFor(input logic [15:0] instr, input logic [5:0] st);
    bundle_t    e;
    logic [4:0] op;
    logic [1:0] op1, op2;
    e = '0;
    op = instr[15:11]; op1 = instr[9:8]; op2 = instr[4:3];
    e.opcode = op; e.param = instr[7:0]; e.lit = instr[7:0];
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        e.rd1 = 1; e.rd2 = 1; e.rs1 = op1; e.rs2 = op2; e.wr = 1; e.ws = op1; e.st = 1; e.sel = 1;
      end
      OP_NOT: begin e.rd2 = 1; e.rs2 = op2; e.wr = 1; e.ws = op1; e.st = 1; e.sel = 1; end
      OP_SHL, OP_SHR: begin e.rd1 = 1; e.rs1 = op1; e.wr = 1; e.ws = op1; e.st = 1; e.sel = 1; end
      OP_VAL:  begin e.wr = 1; e.ws = op1; end
      OP_GOTO: e.cnt = 1;
      OP_IFZ:  begin e.cnt = st[2];  e.add = st[2];  end
      OP_IFNZ: begin e.cnt = !st[2]; e.add = !st[2]; end
      OP_IFEQ: begin e.cnt = st[3];  e.add = st[3];  end
      OP_IFST: begin e.cnt = st[4];  e.add = st[4];  end
      OP_IFGT: begin e.cnt = st[5];  e.add = st[5];  end
      OP_NOP:  ;
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Output monitor: compares each transferred bundle against the next queued expectation.
  initial begin
    bundle_t act, e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && o_out_valid && i_out_ready) begin
        act = {o_opcode, o_param, o_literal_adr, o_rd_en1, o_rd_en2, o_wr_en, o_stat_wr_en,
               o_sel_reg_in_alu_decoder, o_cnt_wr_en, o_add_offset, o_rd_sel1, o_rd_sel2,
               o_wr_sel, o_illegal};
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_bundle: got %h, expected none at %0t", act, $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("bundle", 64'(act), 64'(e));
        end
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    i_in_valid = 0; i_instruction = '0; i_wb_valid = 0; i_stat_wb = 0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 0; i_in_valid = 0; i_instruction = '0; i_status = '0;
    i_wb_valid = 0; i_wb_sel = '0; i_stat_wb = 0; i_out_ready = 1;
    expQ.delete();
    @(negedge clk);
    #3;
    checkOutput("reset_out_valid", 64'(o_out_valid), 64'(0));
    checkOutput("reset_in_ready", 64'(o_in_ready), 64'(1));
    checkOutput("reset_illegal", 64'(o_illegal), 64'(0));
    @(negedge clk);
    rst_n = 1;
  endtask

  // Present a word until accepted (bounded); queue its expectation unless it should be dropped.
  task automatic applyStimulus(input logic [15:0] instr, input logic [5:0] st, input bit keep,
                               input bundle_t exp, output int waits);
    bit done;
    waits = 0;
    done  = 0;
    @(negedge clk);
    i_in_valid = 1; i_instruction = instr; i_status = st;
    while (!done) begin
      #4;
      if (o_in_ready) begin
        done = 1;
        if (keep) expQ.push_back(exp);
      end else begin
        waits++;
        if (waits > WAIT_LIMIT) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept_timeout: instr %h not accepted, waited %0d, limit %0d", instr, waits, WAIT_LIMIT);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_queue_empty", 64'(expQ.size()), 64'(0));
  endtask

  // Hold a word on the input for one cycle and require in_ready low.
  task automatic expectStall(input logic [15:0] instr, input logic [5:0] st, input string name);
    @(negedge clk);
    i_in_valid = 1; i_instruction = instr; i_status = st;
    #4;
    checkOutput(name, 64'(o_in_ready), 64'(0));
    @(posedge clk);
  endtask

  vec_t    vecs[21];
  bundle_t e;
  int      w;

  initial begin
    rst_n = 0; i_in_valid = 0; i_instruction = '0; i_status = '0;
    i_wb_valid = 0; i_wb_sel = '0; i_stat_wb = 0; i_out_ready = 1;

    vecs[0]  = '{OP_ADD,  2'd1, 8'h10, 6'h00, 7'b1111100, 2'd1, 2'd2, 2'd1, 1'b0};
    vecs[1]  = '{OP_SUB,  2'd3, 8'h08, 6'h00, 7'b1111100, 2'd3, 2'd1, 2'd3, 1'b0};
    vecs[2]  = '{OP_AND,  2'd1, 8'h18, 6'h00, 7'b1111100, 2'd1, 2'd3, 2'd1, 1'b0};
    vecs[3]  = '{OP_OR,   2'd0, 8'h08, 6'h00, 7'b1111100, 2'd0, 2'd1, 2'd0, 1'b0};
    vecs[4]  = '{OP_XOR,  2'd2, 8'h1F, 6'h00, 7'b1111100, 2'd2, 2'd3, 2'd2, 1'b0};
    vecs[5]  = '{OP_NOT,  2'd0, 8'h18, 6'h00, 7'b0111100, 2'd0, 2'd3, 2'd0, 1'b0};
    vecs[6]  = '{OP_SHL,  2'd2, 8'h00, 6'h00, 7'b1011100, 2'd2, 2'd0, 2'd2, 1'b0};
    vecs[7]  = '{OP_SHR,  2'd1, 8'hE7, 6'h00, 7'b1011100, 2'd1, 2'd0, 2'd1, 1'b0};
    vecs[8]  = '{OP_VAL,  2'd3, 8'hA5, 6'h00, 7'b0010000, 2'd0, 2'd0, 2'd3, 1'b0};
    vecs[9]  = '{OP_GOTO, 2'd0, 8'h42, 6'h00, 7'b0000010, 2'd0, 2'd0, 2'd0, 1'b0};
    vecs[10] = '{OP_IFZ,  2'd0, 8'h09, 6'h04, 7'b0000011, 2'd0, 2'd0, 2'd0, 1'b0};
    vecs[11] = '{OP_IFNZ, 2'd0, 8'h0B, 6'h04, 7'b0000000, 2'd0, 2'd0, 2'd0, 1'b0};
    vecs[12] = '{OP_IFNZ, 2'd0, 8'h0C, 6'h00, 7'b0000011, 2'd0, 2'd0, 2'd0, 1'b0};
    vecs[13] = '{OP_IFEQ, 2'd0, 8'h33, 6'h08, 7'b0000011, 2'd0, 2'd0, 2'd0, 1'b0};
    vecs[14] = '{OP_IFST, 2'd0, 8'h10, 6'h00, 7'b0000000, 2'd0, 2'd0, 2'd0, 1'b0};
    vecs[15] = '{OP_IFGT, 2'd0, 8'h7F, 6'h20, 7'b0000011, 2'd0, 2'd0, 2'd0, 1'b0};
    vecs[16] = '{OP_IFZ,  2'd0, 8'h01, 6'h3B, 7'b0000000, 2'd0, 2'd0, 2'd0, 1'b0};
    vecs[17] = '{OP_NOP,  2'd0, 8'h77, 6'h00, 7'b0000000, 2'd0, 2'd0, 2'd0, 1'b0};
    vecs[18] = '{5'h0A,   2'd0, 8'h5C, 6'h00, 7'b0000000, 2'd0, 2'd0, 2'd0, 1'b1};
    vecs[19] = '{5'h1F,   2'd0, 8'h01, 6'h00, 7'b0000000, 2'd0, 2'd0, 2'd0, 1'b1};
    vecs[20] = '{5'h16,   2'd0, 8'h80, 6'h00, 7'b0000000, 2'd0, 2'd0, 2'd0, 1'b1};

    for (int i = 0; i < 21; i++) begin
      applyReset();
      e = '0;
      e.opcode = vecs[i].op; e.param = vecs[i].p; e.lit = vecs[i].p;
      {e.rd1, e.rd2, e.wr, e.st, e.sel, e.cnt, e.add} = vecs[i].flags;
      e.rs1 = vecs[i].rs1; e.rs2 = vecs[i].rs2; e.ws = vecs[i].ws; e.ill = vecs[i].ill;
      applyStimulus(mk(vecs[i].op, vecs[i].op1, vecs[i].p), vecs[i].st, 1'b1, e, w);
      checkOutput("table_accept_wait", 64'(w), 64'(0));
      idle();
      drain();
    end

    // RAW stall on r1 until its writeback retires
    applyReset();
    applyStimulus(mk(OP_ADD, 2'd1, 8'h10), 6'h00, 1'b1, expFor(mk(OP_ADD, 2'd1, 8'h10), 6'h00), w);
    for (int k = 0; k < 3; k++) expectStall(mk(OP_SUB, 2'd2, 8'h08), 6'h00, "raw_stall_in_ready");
    @(negedge clk);
    i_wb_valid = 1; i_wb_sel = 2'd1;
    #4;
    checkOutput("raw_stall_wb_cycle", 64'(o_in_ready), 64'(0));
    @(posedge clk);
    #1;
    i_wb_valid = 0;
    applyStimulus(mk(OP_SUB, 2'd2, 8'h08), 6'h00, 1'b1, expFor(mk(OP_SUB, 2'd2, 8'h08), 6'h00), w);
    checkOutput("raw_release_wait_le1", 64'(w <= 1), 64'(1));
    idle();
    drain();

    // Taken IFZ: word after the branch issues, next two are dropped, then issue resumes
    applyReset();
    applyStimulus(mk(OP_IFZ, 2'd0, 8'h09), 6'h04, 1'b1, expFor(mk(OP_IFZ, 2'd0, 8'h09), 6'h04), w);
    applyStimulus(mk(OP_VAL, 2'd0, 8'h11), 6'h04, 1'b1, expFor(mk(OP_VAL, 2'd0, 8'h11), 6'h04), w);
    checkOutput("flush_w1_wait", 64'(w), 64'(0));
    applyStimulus(mk(OP_VAL, 2'd1, 8'h22), 6'h04, 1'b0, '0, w);
    checkOutput("flush_w2_ready", 64'(w), 64'(0));
    applyStimulus(mk(OP_VAL, 2'd2, 8'h33), 6'h04, 1'b0, '0, w);
    checkOutput("flush_w3_ready", 64'(w), 64'(0));
    applyStimulus(mk(OP_VAL, 2'd3, 8'h44), 6'h04, 1'b1, expFor(mk(OP_VAL, 2'd3, 8'h44), 6'h04), w);
    checkOutput("flush_w4_wait", 64'(w), 64'(0));
    idle();
    drain();

    // Not-taken IFNZ, then IFEQ stalls on pending status until stat_wb
    applyReset();
    applyStimulus(mk(OP_IFNZ, 2'd0, 8'h0B), 6'h04, 1'b1, expFor(mk(OP_IFNZ, 2'd0, 8'h0B), 6'h04), w);
    applyStimulus(mk(OP_ADD, 2'd1, 8'h10), 6'h04, 1'b1, expFor(mk(OP_ADD, 2'd1, 8'h10), 6'h04), w);
    checkOutput("nflush_add_wait", 64'(w), 64'(0));
    for (int k = 0; k < 3; k++) expectStall(mk(OP_IFEQ, 2'd0, 8'h33), 6'h08, "status_stall_in_ready");
    @(negedge clk);
    i_stat_wb = 1;
    #4;
    checkOutput("status_stall_wb_cycle", 64'(o_in_ready), 64'(0));
    @(posedge clk);
    #1;
    i_stat_wb = 0;
    applyStimulus(mk(OP_IFEQ, 2'd0, 8'h33), 6'h08, 1'b1, expFor(mk(OP_IFEQ, 2'd0, 8'h33), 6'h08), w);
    checkOutput("status_release_wait_le1", 64'(w <= 1), 64'(1));
    idle();
    drain();

    // Reserved opcode with back-pressure: illegal pulses once, bundle held, input stalled
    applyReset();
    i_out_ready = 0;
    e = expFor(mk(5'h0A, 2'd0, 8'h5C), 6'h00);
    e.ill = 0;
    applyStimulus(mk(5'h0A, 2'd0, 8'h5C), 6'h00, 1'b1, e, w);
    @(negedge clk);
    i_instruction = mk(OP_VAL, 2'd3, 8'h44);
    #3;
    checkOutput("illegal_first_valid", 64'(o_out_valid), 64'(1));
    checkOutput("illegal_pulse", 64'(o_illegal), 64'(1));
    checkOutput("illegal_wr_en", 64'(o_wr_en), 64'(0));
    checkOutput("illegal_in_ready", 64'(o_in_ready), 64'(0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #3;
      checkOutput("hold_illegal_low", 64'(o_illegal), 64'(0));
      checkOutput("hold_valid", 64'(o_out_valid), 64'(1));
      checkOutput("hold_opcode", 64'(o_opcode), 64'(5'h0A));
      checkOutput("hold_param", 64'(o_param), 64'(8'h5C));
      checkOutput("hold_in_ready", 64'(o_in_ready), 64'(0));
    end
    @(negedge clk);
    i_in_valid = 0;
    i_out_ready = 1;
    @(posedge clk);
    applyStimulus(mk(OP_VAL, 2'd3, 8'h44), 6'h00, 1'b1, expFor(mk(OP_VAL, 2'd3, 8'h44), 6'h00), w);
    idle();
    drain();

    // Asynchronous reset in the middle of a RAW stall
    applyReset();
    applyStimulus(mk(OP_ADD, 2'd1, 8'h10), 6'h00, 1'b1, expFor(mk(OP_ADD, 2'd1, 8'h10), 6'h00), w);
    for (int k = 0; k < 2; k++) expectStall(mk(OP_SUB, 2'd2, 8'h08), 6'h00, "pre_reset_stall");
    #2;
    rst_n = 0;
    #1;
    checkOutput("midreset_out_valid", 64'(o_out_valid), 64'(0));
    checkOutput("midreset_illegal", 64'(o_illegal), 64'(0));
    expQ.delete();
    @(negedge clk);
    rst_n = 1;
    #3;
    checkOutput("post_reset_in_ready", 64'(o_in_ready), 64'(1));
    checkOutput("post_reset_out_valid", 64'(o_out_valid), 64'(0));
    expQ.push_back(expFor(mk(OP_SUB, 2'd2, 8'h08), 6'h00));
    @(posedge clk);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
